ifq: RTL and testbench

//  Instruction fetch queue, directly downstream of the icache. Generates the

---
 rtl/ifq_if.sv | 33 +++
 rtl/ifq.sv | 117 +++++++++++
 tb/tb_ifq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ifq_if.sv
// Bundles the icache-facing and dispatch-facing signals of the instruction fetch queue.
// Latency: n/a (wires only).
// Backpressure: n/a. Flow control is ifq_ren/icache_din_valid on the fetch side and ifq_empty/dispatch_ren on the dispatch side.
//
// Modports:
//   slave  - the fetch queue itself (drives fetch PC, read enable, head instruction)
//   master - the surrounding environment (icache + dispatch)
interface ifq_if #(
  parameter int W_DATA = 32,
  parameter int W_LINE = 128
);
  logic [W_DATA-1:0] ifq_pcout;
  logic              ifq_ren;
  logic              ifq_abort;
  logic [W_LINE-1:0] icache_din;
  logic              icache_din_valid;
  logic [W_DATA-1:0] jmp_branch_addr;
  logic              jmp_branch_valid;
  logic              dispatch_ren;
  logic [W_DATA-1:0] ifq_dout;
  logic [W_DATA-1:0] ifq_pc_out;
  logic              ifq_empty;

  modport slave (
    input  icache_din, icache_din_valid, jmp_branch_addr, jmp_branch_valid, dispatch_ren,
    output ifq_pcout, ifq_ren, ifq_abort, ifq_dout, ifq_pc_out, ifq_empty
  );

  modport master (
    output icache_din, icache_din_valid, jmp_branch_addr, jmp_branch_valid, dispatch_ren,
    input  ifq_pcout, ifq_ren, ifq_abort, ifq_dout, ifq_pc_out, ifq_empty
  );
endinterface

// File: rtl/ifq.sv
// Instruction fetch queue: fetches aligned icache lines, buffers DEPTH lines, hands out one word per dispatch read.
// Latency: a line written on edge N is visible at ifq_dout after edge N; dout itself is combinational from the head line.
// Backpressure: ifq_ren drops while the queue is full or a redirect is pending; a dispatch_ren while empty is ignored.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - ifq_if.slave. Fetch side: ifq_pcout, ifq_ren, ifq_abort, icache_din, icache_din_valid.
//           Redirect: jmp_branch_addr, jmp_branch_valid. Dispatch: dispatch_ren, ifq_dout, ifq_pc_out, ifq_empty.
module ifq #(
  parameter int                W_DATA   = 32,
  parameter int                W_LINE   = 128,
  parameter int                DEPTH    = 4,
  parameter logic [W_DATA-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  ifq_if.slave bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WPL = W_LINE / W_DATA;      // words per line
  localparam int OW  = $clog2(WPL);          // word-offset width
  localparam int WB  = $clog2(W_DATA / 8);   // byte-address bits inside a word

  localparam logic [W_DATA-1:0] LINE_BYTES = W_DATA'(W_LINE / 8);
  localparam logic [W_DATA-1:0] WORD_BYTES = W_DATA'(W_DATA / 8);
  localparam logic [W_DATA-1:0] LINE_MASK  = ~(LINE_BYTES - W_DATA'(1));
  localparam logic [W_DATA-1:0] WORD_MASK  = ~(WORD_BYTES - W_DATA'(1));

  logic [W_LINE-1:0] mem_q [DEPTH];

  logic [AW:0]       wr_ptr_q,   wr_ptr_d;
  logic [AW:0]       rd_ptr_q,   rd_ptr_d;
  logic [OW-1:0]     off_q,      off_d;
  logic [W_DATA-1:0] fetch_pc_q, fetch_pc_d;
  logic [W_DATA-1:0] disp_pc_q,  disp_pc_d;

  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic [W_LINE-1:0] head_line;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // No bypass: a full queue never requests, even if the head is leaving this cycle.
  assign bus.ifq_ren   = reset & ~full & ~bus.jmp_branch_valid;
  assign bus.ifq_abort = bus.jmp_branch_valid;

  assign wr_en = bus.ifq_ren & bus.icache_din_valid;
  assign rd_en = bus.dispatch_ren & ~empty & ~bus.jmp_branch_valid;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    off_d      = off_q;
    fetch_pc_d = fetch_pc_q;
    disp_pc_d  = disp_pc_q;

    if (bus.jmp_branch_valid) begin
      // Redirect wins: drop queued lines, refetch the target's line and
      // start reading at the target's word inside that line.
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = bus.jmp_branch_addr & LINE_MASK;
      off_d      = bus.jmp_branch_addr[WB +: OW];
      disp_pc_d  = bus.jmp_branch_addr & WORD_MASK;
    end else begin
      if (wr_en) begin
        wr_ptr_d   = wr_ptr_q + (AW+1)'(1);
        fetch_pc_d = fetch_pc_q + LINE_BYTES;
      end
      if (rd_en) begin
        disp_pc_d = disp_pc_q + WORD_BYTES;
        // Offset wraps to 0 after the last word, so every line after the
        // first one post-redirect starts at word 0.
        off_d     = off_q + OW'(1);
        if (off_q == {OW{1'b1}}) begin
          rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      off_q      <= '0;
      fetch_pc_q <= RESET_PC & LINE_MASK;
      disp_pc_q  <= RESET_PC;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      off_q      <= off_d;
      fetch_pc_q <= fetch_pc_d;
      disp_pc_q  <= disp_pc_d;
    end
  end

  // Line storage carries no reset; empty gating on the output hides stale data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.icache_din;
    end
  end

  assign head_line = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.ifq_pcout  = fetch_pc_q;
  assign bus.ifq_pc_out = disp_pc_q;
  assign bus.ifq_empty  = empty;
  assign bus.ifq_dout   = empty ? '0 : head_line[int'(off_q) * W_DATA +: W_DATA];

endmodule

// File: tb/tb_ifq.sv
// Scoreboard bench for ifq: stimulus pushes expected {pc, instr}; negedge monitor pops on each dispatch read.
// Latency: icache model is zero-latency, data is a pure function of ifq_pcout.
// Backpressure: the bench honours ifq_ren via the DUT; dispatch_ren is driven directly.
module tb_ifq;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb [$];

  ifq_if #(.W_DATA(32), .W_LINE(128)) bus ();

  ifq #(.W_DATA(32), .W_LINE(128), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Icache model: the word at byte address a holds ~a.
  assign bus.icache_din = {~(bus.ifq_pcout + 32'd12), ~(bus.ifq_pcout + 32'd8),
                           ~(bus.ifq_pcout + 32'd4),  ~bus.ifq_pcout};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc0, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc  = pc0 + 32'(4 * i);
      e.ins = ~e.pc;
      sb.push_back(e);
    end
  endtask

  // Monitor: an accepted dispatch read must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.dispatch_ren && !bus.ifq_empty && !bus.jmp_branch_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected actual_pc=%h required=none", bus.ifq_pc_out);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.ifq_pc_out !== e.pc || bus.ifq_dout !== e.ins) begin
          errors++;
          $display("FAIL mon_instr actual_pc=%h actual_dout=%h required_pc=%h required_dout=%h",
                   bus.ifq_pc_out, bus.ifq_dout, e.pc, e.ins);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset                = 1'b0;
    bus.icache_din_valid = 1'b1;
    bus.jmp_branch_addr  = 32'h0;
    bus.jmp_branch_valid = 1'b0;
    bus.dispatch_ren     = 1'b0;

    // Reset state
    #12;
    chk("rst_empty", 32'(bus.ifq_empty), 32'd1);
    chk("rst_dout",  bus.ifq_dout,       32'h0);
    chk("rst_ren",   32'(bus.ifq_ren),   32'd0);
    chk("rst_abort", 32'(bus.ifq_abort), 32'd0);
    chk("rst_pcout", bus.ifq_pcout,      32'h0);
    chk("rst_pc",    bus.ifq_pc_out,     32'h0);

    // Fill: four lines at 0,16,32,48 then full
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_pcout", bus.ifq_pcout,    32'(16 * i));
      chk("fill_ren",   32'(bus.ifq_ren), 32'd1);
      tick();
    end
    chk("full_ren",   32'(bus.ifq_ren),   32'd0);
    chk("full_pcout", bus.ifq_pcout,      32'd64);
    chk("full_empty", 32'(bus.ifq_empty), 32'd0);
    chk("full_pc",    bus.ifq_pc_out,     32'd0);
    chk("full_dout",  bus.ifq_dout,       ~32'd0);

    // Drain 16 words; ren reasserts each time a head line frees
    push(32'h0, 16);
    bus.dispatch_ren = 1'b1;
    for (int c = 0; c < 16; c++) begin
      chk("drain_nogap", 32'(bus.ifq_empty), 32'd0);
      chk("drain_ren",   32'(bus.ifq_ren),   32'((c > 0) && (c % 4 == 0)));
      tick();
    end
    bus.dispatch_ren = 1'b0;
    chk("drain_ren_after", 32'(bus.ifq_ren), 32'd1);
    tick();
    chk("refull_ren",   32'(bus.ifq_ren), 32'd0);
    chk("refull_pcout", bus.ifq_pcout,    32'd128);

    // Redirect to mid-line target while full
    bus.jmp_branch_addr  = 32'h0000_0108;
    bus.jmp_branch_valid = 1'b1;
    #1;
    chk("redir_abort", 32'(bus.ifq_abort), 32'd1);
    chk("redir_ren",   32'(bus.ifq_ren),   32'd0);
    tick();
    bus.jmp_branch_valid = 1'b0;
    bus.icache_din_valid = 1'b0;
    #1;
    chk("redir_empty", 32'(bus.ifq_empty), 32'd1);
    chk("redir_pcout", bus.ifq_pcout,      32'h100);
    chk("redir_abort_clr", 32'(bus.ifq_abort), 32'd0);

    // icache data invalid for 3 cycles: no write, PC held
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("inval_pcout", bus.ifq_pcout,      32'h100);
      chk("inval_empty", 32'(bus.ifq_empty), 32'd1);
    end
    bus.icache_din_valid = 1'b1;
    tick();
    chk("refetch_empty", 32'(bus.ifq_empty), 32'd0);
    chk("refetch_pc",    bus.ifq_pc_out,     32'h108);
    chk("refetch_dout",  bus.ifq_dout,       ~32'h108);
    chk("refetch_pcout", bus.ifq_pcout,      32'h110);

    // Steady stream from the redirect target: one instruction per cycle
    push(32'h108, 14);
    bus.dispatch_ren = 1'b1;
    for (int i = 0; i < 14; i++) begin
      chk("steady_nogap", 32'(bus.ifq_empty), 32'd0);
      tick();
    end
    bus.dispatch_ren = 1'b0;

    // Asynchronous reset mid-stream, off the clock edge
    #3;
    reset = 1'b0;
    #1;
    chk("mrst_empty", 32'(bus.ifq_empty), 32'd1);
    chk("mrst_dout",  bus.ifq_dout,       32'h0);
    chk("mrst_ren",   32'(bus.ifq_ren),   32'd0);
    chk("mrst_pcout", bus.ifq_pcout,      32'h0);
    chk("mrst_pc",    bus.ifq_pc_out,     32'h0);
    #2;
    reset = 1'b1;
    // dispatch_ren held high while still empty must be ignored
    push(32'h0, 4);
    bus.dispatch_ren = 1'b1;
    tick();
    chk("restart_pcout", bus.ifq_pcout,      32'd16);
    chk("restart_empty", 32'(bus.ifq_empty), 32'd0);
    chk("restart_pc",    bus.ifq_pc_out,     32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    bus.dispatch_ren = 1'b0;
    chk("restart_pc2",   bus.ifq_pc_out, 32'd16);
    chk("restart_dout2", bus.ifq_dout,   ~32'd16);

    #10;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
